// File: rtl/count_tick_ctrl.sv
// Run/step enable-strobe generator for the decade counter: button sync + debounce,
// run/step FSM and programmable prescaler. Define TICK_AUTOSTOP_EN to stop RUN after STOP_AFTER strobes.
module count_tick_ctrl #(
    parameter int unsigned DIV_W      = 24,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned DEB_W      = 3,
    parameter int unsigned STOP_AFTER = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic [DIV_W-1:0] div_val,
    output logic             en_out,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    // index 0 = run button, index 1 = step button
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_lvl_q, deb_lvl_d;
    logic [1:0]       deb_prev_q;
    logic [DEB_W-1:0] deb_cnt_q [2];
    logic [DEB_W-1:0] deb_cnt_d [2];
    logic [1:0]       press;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] prescaler_q, prescaler_d;
    logic             en_q, en_d;
    logic [DIV_W-1:0] div_eff;

`ifdef TICK_AUTOSTOP_EN
    localparam int unsigned STOP_W = $clog2(STOP_AFTER + 1);
    logic [STOP_W-1:0] strb_cnt_q, strb_cnt_d;
`endif

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            deb_lvl_d[i] = deb_lvl_q[i];
            if (sync2_q[i] != deb_lvl_q[i]) begin
                if (deb_cnt_q[i] >= DEB_W'(DEB_CYCLES - 1))
                    deb_lvl_d[i] = ~deb_lvl_q[i];
                else
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    assign press   = deb_lvl_q & ~deb_prev_q;
    assign div_eff = (div_val <= DIV_W'(1)) ? DIV_W'(1) : div_val;

    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        en_d        = 1'b0;
`ifdef TICK_AUTOSTOP_EN
        strb_cnt_d  = strb_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                prescaler_d = '0;
                if (press[0]) begin
                    state_d = RUN;
`ifdef TICK_AUTOSTOP_EN
                    strb_cnt_d = '0;
`endif
                end else if (press[1]) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                // a run press wins over a strobe due on the same edge
                if (press[0]) begin
                    state_d     = IDLE;
                    prescaler_d = '0;
                end else if (prescaler_q >= div_eff - DIV_W'(1)) begin
                    prescaler_d = '0;
                    en_d        = 1'b1;
`ifdef TICK_AUTOSTOP_EN
                    strb_cnt_d = strb_cnt_q + STOP_W'(1);
                    if (strb_cnt_q == STOP_W'(STOP_AFTER - 1))
                        state_d = IDLE;
`endif
                end else begin
                    prescaler_d = prescaler_q + DIV_W'(1);
                end
            end
            STEP: begin
                state_d = IDLE;
                en_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_lvl_q    <= '0;
            deb_prev_q   <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            state_q      <= IDLE;
            prescaler_q  <= '0;
            en_q         <= 1'b0;
`ifdef TICK_AUTOSTOP_EN
            strb_cnt_q   <= '0;
`endif
        end else begin
            sync1_q      <= {btn_step, btn_run};
            sync2_q      <= sync1_q;
            deb_lvl_q    <= deb_lvl_d;
            deb_prev_q   <= deb_lvl_q;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
            state_q      <= state_d;
            prescaler_q  <= prescaler_d;
            en_q         <= en_d;
`ifdef TICK_AUTOSTOP_EN
            strb_cnt_q   <= strb_cnt_d;
`endif
        end
    end

    assign en_out  = en_q;
    assign running = (state_q == RUN);

endmodule
